alu_add_seq: RTL and testbench

Multi-precision add sequencer. It builds an `8*NBYTES`-bit unsigned addition out of a single shared 8-bit adder, stepping one byte per cycle LSB-first. The shared adder has no carry input, so an incoming carry costs one extra increment pass on that byte. The block sits between the instruction-level ALU front end (valid/ready request) and the 8-bit adder datapath, which it instantiates internally.

---
 rtl/alu_add_seq.sv | 151 +++++++++++++++
 tb/tb_alu_add_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_add_seq.sv
// alu_add_seq: multi-precision unsigned add sequencer built on one shared 8-bit adder.
// The adder processes one byte per cycle, starting with the least significant byte.
// The adder has no carry input, so a byte that receives a carry takes an extra
// increment (INC) pass.
// Optional feature: define ALU_ADD_SEQ_CARRYIN_EN to add the cin port.
module alu_add_seq #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
`ifdef ALU_ADD_SEQ_CARRYIN_EN
    input  logic                  cin,
`endif
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout
);

    localparam int unsigned IdxW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);

    typedef enum logic [1:0] {StIdle, StAdd, StInc, StDone} state_e;

    state_e                  state_q, state_d;
    logic [NBYTES-1:0][7:0]  ra_q, ra_d;
    logic [NBYTES-1:0][7:0]  rb_q, rb_d;
    logic [NBYTES-1:0][7:0]  sum_q, sum_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic                    carry_q, carry_d;
    logic                    c1_q, c1_d;
    logic                    cout_q, cout_d;

    logic [7:0]              op_x, op_y;
    logic [8:0]              add_res;
    logic                    carry_new;
    logic                    advance;
    logic                    cin_int;

`ifdef ALU_ADD_SEQ_CARRYIN_EN
    assign cin_int = cin;
`else
    assign cin_int = 1'b0;
`endif

    // Shared 8-bit adder: operands come from the operand registers in ADD and from the
    // partial result plus one in INC.
    always_comb begin
        op_x = ra_q[idx_q];
        op_y = rb_q[idx_q];
        if (state_q == StInc) begin
            op_x = sum_q[idx_q];
            op_y = 8'h01;
        end
        add_res = {1'b0, op_x} + {1'b0, op_y};
    end

    // Next-state logic: sequencing, byte writes, and carry tracking.
    always_comb begin
        state_d   = state_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        sum_d     = sum_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        c1_d      = c1_q;
        cout_d    = cout_q;
        carry_new = 1'b0;
        advance   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    ra_d    = a;
                    rb_d    = b;
                    idx_d   = '0;
                    carry_d = cin_int;
                    state_d = StAdd;
                end
            end
            StAdd: begin
                sum_d[idx_q] = add_res[7:0];
                c1_d         = add_res[8];
                if (carry_q) begin
                    state_d = StInc;
                end else begin
                    carry_new = add_res[8];
                    advance   = 1'b1;
                end
            end
            StInc: begin
                sum_d[idx_q] = add_res[7:0];
                // The ADD pass overflow and the increment overflow are mutually exclusive.
                carry_new    = c1_q | add_res[8];
                advance      = 1'b1;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (advance) begin
            carry_d = carry_new;
            if (idx_q == LastIdx) begin
                cout_d  = carry_new;
                state_d = StDone;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = StAdd;
            end
        end
    end

    // State registers with synchronous reset; a reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ra_q    <= '0;
            rb_q    <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            c1_q    <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            c1_q    <= c1_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q == StAdd) || (state_q == StInc);
    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_alu_add_seq.sv
// Bench for alu_add_seq with NBYTES=4. An independent bytewise model predicts the sum,
// carry-out and latency. The bench pushes each prediction to a queue at accept and pops
// it when out_valid rises.
module tb_alu_add_seq;

    localparam int unsigned NB = 4;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin_r;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    alu_add_seq #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef ALU_ADD_SEQ_CARRYIN_EN
        .cin       (cin_r),
`endif
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bytewise model: the latency is NBYTES plus the number of bytes that receive a carry.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic c);
        exp_t        e;
        logic [32:0] t;
        logic [8:0]  bs;
        logic        cc;
        int          k;
        t      = {1'b0, x} + {1'b0, y} + {32'b0, c};
        e.sum  = t[31:0];
        e.cout = t[32];
        cc     = c;
        k      = 0;
        for (int i = 0; i < 4; i++) begin
            if (cc) k++;
            bs = {1'b0, x[i*8 +: 8]} + {1'b0, y[i*8 +: 8]} + {8'b0, cc};
            cc = bs[8];
        end
        e.lat = 4 + k;
        return e;
    endfunction

    // Issues one request, then checks the result, the latency and the busy window.
    // Holds out_ready low for 'hold' cycles in DONE before completing the handshake.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic c,
                          input string name, input int hold);
        exp_t e;
        int   lat;
        int   bcnt;
        int   w;
        w = 0;
        while (!in_ready && w < 20) begin
            step();
            w++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept_wait: in_ready=%b required 1", name, in_ready);
            return;
        end
        in_valid = 1'b1;
        a        = x;
        b        = y;
        cin_r    = c;
        sb.push_back(model(x, y, c));
        step();
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        cin_r    = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s accepted: busy=%b in_ready=%b required 1/0", name, busy, in_ready);
        end
        lat  = 0;
        bcnt = 0;
        while (!out_valid && lat < 40) begin
            if (busy) bcnt++;
            step();
            lat++;
        end
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: out_valid=%b required 1", name, out_valid);
            return;
        end
        checks++;
        if (sum !== e.sum || cout !== e.cout) begin
            errors++;
            $display("FAIL %s result: sum=%h cout=%b required sum=%h cout=%b",
                     name, sum, cout, e.sum, e.cout);
        end
        checks++;
        if (lat != e.lat || bcnt != e.lat) begin
            errors++;
            $display("FAIL %s latency: latency=%0d busy_cycles=%0d required %0d",
                     name, lat, bcnt, e.lat);
        end
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            step();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== e.sum || cout !== e.cout) begin
                errors++;
                $display("FAIL %s hold%0d: ov=%b ir=%b sum=%h cout=%b required 1 0 %h %b",
                         name, i, out_valid, in_ready, sum, cout, e.sum, e.cout);
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s release: in_ready=%b out_valid=%b busy=%b required 1 0 0",
                     name, in_ready, out_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 ||
            sum !== 32'h0 || cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ir=%b busy=%b ov=%b sum=%h cout=%b required 1 0 0 0 0",
                     in_ready, busy, out_valid, sum, cout);
        end
    endtask

    task automatic test_add();
        run_op(32'h0000_0001, 32'h0000_0002, 1'b0, "add_simple", 0);
        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, "add_carry_b1", 0);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "add_ripple", 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "add_max", 0);
        run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, "add_mixed", 0);
        for (int i = 0; i < 6; i++) begin
            run_op($urandom, $urandom, 1'b0, "add_random", 0);
        end
    endtask

    task automatic test_back_to_back();
        run_op(32'h00FF_00FF, 32'h0001_0001, 1'b0, "b2b_first", 5);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, "b2b_second", 0);
    endtask

    task automatic test_reset_abort();
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            step();
            w++;
        end
        in_valid = 1'b1;
        a        = 32'hFFFF_FFFF;
        b        = 32'h0000_0001;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== 32'h0) begin
            errors++;
            $display("FAIL reset_abort: ir=%b ov=%b busy=%b sum=%h required 1 0 0 0",
                     in_ready, out_valid, busy, sum);
        end
        run_op(32'h0000_0010, 32'h0000_0020, 1'b0, "after_abort", 0);
    endtask

`ifdef ALU_ADD_SEQ_CARRYIN_EN
    task automatic test_carry_in();
        run_op(32'h0000_0000, 32'h0000_0000, 1'b1, "cin_zero", 0);
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "cin_ripple", 0);
    endtask
`endif

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin_r     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_add();
        test_back_to_back();
        test_reset_abort();
`ifdef ALU_ADD_SEQ_CARRYIN_EN
        test_carry_in();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
